// File: rtl/level_display_pkg.sv
// Shared segment encodings, helper functions and FSM encoding for the
// level_display seven-segment readout.
package level_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_V     = 7'b1000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_UPDATE
  } state_t;

  // Decimal digits needed for a w-bit value: ceil(w * log10(2)), with log10(2)
  // held as a rounded-up fixed-point constant scaled by 1e6.
  function automatic int bcd_digits(input int w);
    int acc;
    acc = 0;
    for (int i = 0; i < w; i++) begin
      acc += 301030;
    end
    return (acc + 999999) / 1000000;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/level_display_bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per cycle, VALUE_W cycles
// per conversion; done flags the cycle in which the final iteration happens.
module bin2bcd_seq
  import level_display_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int NBCD    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VALUE_W-1:0]   bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [NBCD*4-1:0]    bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [NBCD*4-1:0]  bcd_q, bcd_d;
  logic [NBCD*4-1:0]  adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = CNT_W'(VALUE_W);
    end else if (cnt_q != '0) begin
      // Adjusted BCD shifts left, pulling in the binary MSB.
      bcd_d = {adj[NBCD*4-2:0], bin_q[VALUE_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/level_display.sv
// "LV" + decimal level readout: converts on change, holds the last stable
// reading while converting, blanks leading zeros, flags overflow, blinks on change.
module level_display
  import level_display_pkg::*;
#(
  parameter int VALUE_W     = 8,
  parameter int DIGITS      = 3,
  parameter int LZ_BLANK    = 1,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int BLINK_COUNT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  on,
  output logic [DIGITS*7-1:0]   hex_digits,
  output logic [13:0]           hex_prefix,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NBCD_RAW = bcd_digits(VALUE_W);
  localparam int NBCD     = (NBCD_RAW > 0) ? NBCD_RAW : 1;
  localparam int NW       = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PH_W     = $clog2(2 * BLINK_COUNT + 2);

  state_t              state_q, state_d;
  logic [VALUE_W-1:0]  last_value_q, last_value_d;
  logic [NW*4-1:0]     disp_bcd_q, disp_bcd_d;
  logic                overflow_q, overflow_d;
  logic                blink_q, blink_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [DIV_W-1:0]    div_q, div_d;

  logic                conv_start, conv_busy, conv_done;
  logic [NBCD*4-1:0]   conv_bcd;
  logic [NW*4-1:0]     conv_ext;
  logic                conv_ovf;
  logic                blink_start;
  logic                blink_off;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .NBCD    (NBCD)
  ) u_bin2bcd (
    .clk    (CLK),
    .rst    (RST),
    .start  (conv_start),
    .bin_in (value),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Zero-extend the converter result so it always covers the displayed digits.
  always_comb begin
    conv_ext = '0;
    conv_ext[NBCD*4-1:0] = conv_bcd;
    conv_ovf = 1'b0;
    for (int i = DIGITS; i < NW; i++) begin
      if (conv_ext[i*4 +: 4] != 4'd0) begin
        conv_ovf = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    disp_bcd_d   = disp_bcd_q;
    overflow_d   = overflow_q;
    conv_start   = 1'b0;
    blink_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (value != last_value_q) begin
          last_value_d = value;
          conv_start   = 1'b1;
          state_d      = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        disp_bcd_d  = conv_ext;
        overflow_d  = conv_ovf;
        blink_start = (BLINK_COUNT > 0) && (conv_ext != disp_bcd_q);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phases alternate off/on starting with off; a fresh start always restarts at phase 0.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    div_d   = div_q;
    if (blink_start) begin
      blink_d = 1'b1;
      phase_d = '0;
      div_d   = '0;
    end else if (blink_q) begin
      if (div_q == DIV_W'(BLINK_DIV - 1)) begin
        div_d = '0;
        if (phase_q == PH_W'(2 * BLINK_COUNT - 1)) begin
          blink_d = 1'b0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      last_value_q <= '0;
      disp_bcd_q   <= '0;
      overflow_q   <= 1'b0;
      blink_q      <= 1'b0;
      phase_q      <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      disp_bcd_q   <= disp_bcd_d;
      overflow_q   <= overflow_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
    end
  end

  assign blink_off = blink_q && !phase_q[0];

  // Walk from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    logic       seen_nz;
    logic [3:0] nib;
    logic [6:0] seg;
    hex_digits = '1;
    seen_nz    = 1'b0;
    nib        = 4'd0;
    seg        = SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_bcd_q[i*4 +: 4];
      if (overflow_q) begin
        seg = SEG_DASH;
      end else if ((LZ_BLANK != 0) && (i != 0) && !seen_nz && (nib == 4'd0)) begin
        seg = SEG_BLANK;
      end else begin
        seg = seg_of(nib);
      end
      if (nib != 4'd0) begin
        seen_nz = 1'b1;
      end
      if (on && !blink_off) begin
        hex_digits[i*7 +: 7] = seg;
      end
    end
  end

  assign hex_prefix = on ? {SEG_L, SEG_V} : 14'h3fff;
  assign busy       = conv_busy || (state_q == ST_UPDATE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_level_display.sv
// Self-checking bench for level_display: three instances cover default digits,
// two-digit overflow without blanking, and a short blink sequence.
module tb_level_display;

  typedef struct {
    logic [20:0] hex;
    logic        ovf;
  } exp_t;

  localparam logic [13:0] LV = {7'b1000111, 7'b1000001};
  localparam int W = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [7:0]  value_a = 8'd0, value_b = 8'd0, value_c = 8'd3;
  logic        on_a = 1'b1, on_b = 1'b1, on_c = 1'b1;
  logic [20:0] hd_a, hd_c;
  logic [13:0] hd_b;
  logic [13:0] hp_a, hp_b, hp_c;
  logic        busy_a, busy_b, busy_c;
  logic        ovf_a, ovf_b, ovf_c;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  level_display #(.BLINK_COUNT(0)) dut_a (
    .CLK(CLK), .RST(RST), .value(value_a), .on(on_a),
    .hex_digits(hd_a), .hex_prefix(hp_a), .busy(busy_a), .overflow(ovf_a)
  );

  level_display #(.DIGITS(2), .LZ_BLANK(0), .BLINK_COUNT(0)) dut_b (
    .CLK(CLK), .RST(RST), .value(value_b), .on(on_b),
    .hex_digits(hd_b), .hex_prefix(hp_b), .busy(busy_b), .overflow(ovf_b)
  );

  level_display #(.BLINK_DIV(4), .BLINK_COUNT(2)) dut_c (
    .CLK(CLK), .RST(RST), .value(value_c), .on(on_c),
    .hex_digits(hd_c), .hex_prefix(hp_c), .busy(busy_c), .overflow(ovf_c)
  );

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t[10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // Reference readout built by repeated division, independent of double-dabble.
  function automatic exp_t model(input int v, input int ndig, input bit lz);
    exp_t e;
    int   x;
    e.hex = '1;
    e.ovf = (v >= 10 ** ndig);
    x = v;
    for (int i = 0; i < ndig; i++) begin
      if (e.ovf) e.hex[i*7 +: 7] = 7'b0111111;
      else if (lz && i > 0 && x == 0) e.hex[i*7 +: 7] = 7'b1111111;
      else e.hex[i*7 +: 7] = seg_ref(x % 10);
      x = x / 10;
    end
    return e;
  endfunction

  // Waits (bounded) for the chosen instance's busy to rise and fall; returns busy cycle count.
  task automatic wait_conv(input int which, output int cycles);
    bit   seen;
    logic b;
    cycles = 0;
    seen   = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
      if (b) begin
        cycles++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (hd_a !== {7'h7f, 7'h7f, 7'b1000000}) begin
      tests_failed++; $display("[TB] FAIL reset_digits got %h want %h", hd_a, {7'h7f, 7'h7f, 7'b1000000});
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy_a);
    end
    tests_run++;
    if (ovf_a !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_overflow got %b want 0", ovf_a);
    end
    tests_run++;
    if (hp_a !== LV) begin
      tests_failed++; $display("[TB] FAIL reset_prefix got %h want %h", hp_a, LV);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_convert();
    int   vals[5] = '{27, 255, 100, 8, 0};
    int   cyc;
    exp_t e;
    foreach (vals[n]) begin
      value_a = 8'(vals[n]);
      sb_a.push_back(model(vals[n], 3, 1'b1));
      wait_conv(0, cyc);
      tests_run++;
      if (cyc !== W + 1) begin
        tests_failed++; $display("[TB] FAIL busy_len_%0d got %0d want %0d", vals[n], cyc, W + 1);
      end
      e = sb_a.pop_front();
      tests_run++;
      if (hd_a !== e.hex || ovf_a !== e.ovf) begin
        tests_failed++;
        $display("[TB] FAIL convert_%0d got %h/%b want %h/%b", vals[n], hd_a, ovf_a, e.hex, e.ovf);
      end
    end
  endtask

  task automatic test_overflow_no_blank();
    int   vals[3] = '{5, 123, 99};
    int   cyc;
    exp_t e;
    logic [13:0] want;
    foreach (vals[n]) begin
      value_b = 8'(vals[n]);
      sb_b.push_back(model(vals[n], 2, 1'b0));
      wait_conv(1, cyc);
      e = sb_b.pop_front();
      want = e.hex[13:0];
      tests_run++;
      if (hd_b !== want || ovf_b !== e.ovf) begin
        tests_failed++;
        $display("[TB] FAIL two_digit_%0d got %h/%b want %h/%b", vals[n], hd_b, ovf_b, want, e.ovf);
      end
    end
  endtask

  task automatic test_blink();
    int   cyc;
    exp_t e;
    logic [20:0] want;
    value_c = 8'd4;
    sb_c.push_back(model(4, 3, 1'b1));
    wait_conv(2, cyc);
    e = sb_c.pop_front();
    for (int j = 0; j < 20; j++) begin
      want = (j < 4 || (j >= 8 && j < 12)) ? 21'h1fffff : e.hex;
      tests_run++;
      if (hd_c !== want || hp_c !== LV) begin
        tests_failed++;
        $display("[TB] FAIL blink_cycle_%0d got %h/%h want %h/%h", j, hd_c, hp_c, want, LV);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    int   gap;
    exp_t e;
    value_a = 8'd10;
    sb_a.push_back(model(10, 3, 1'b1));
    repeat (3) @(negedge CLK);
    value_a = 8'd11;
    sb_a.push_back(model(11, 3, 1'b1));
    wait_conv(0, cyc);
    e = sb_a.pop_front();
    tests_run++;
    if (hd_a !== e.hex) begin
      tests_failed++; $display("[TB] FAIL inflight_10 got %h want %h", hd_a, e.hex);
    end
    gap = 1;
    for (int k = 0; k < 5 && !busy_a; k++) begin
      @(negedge CLK);
      if (!busy_a) gap++;
    end
    tests_run++;
    if (gap !== 1) begin
      tests_failed++; $display("[TB] FAIL reconvert_gap got %0d want 1", gap);
    end
    wait_conv(0, cyc);
    e = sb_a.pop_front();
    tests_run++;
    if (hd_a !== e.hex) begin
      tests_failed++; $display("[TB] FAIL settle_11 got %h want %h", hd_a, e.hex);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    exp_t e;
    value_a = 8'd200;
    sb_a.push_back(model(200, 3, 1'b1));
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    tests_run++;
    if (hd_a !== {7'h7f, 7'h7f, 7'b1000000} || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset got %h/%b/%b want %h/0/0", hd_a, busy_a, ovf_a, {7'h7f, 7'h7f, 7'b1000000});
    end
    @(negedge CLK);
    RST = 1'b0;
    wait_conv(0, cyc);
    tests_run++;
    if (cyc !== W + 1) begin
      tests_failed++; $display("[TB] FAIL post_reset_busy got %0d want %0d", cyc, W + 1);
    end
    e = sb_a.pop_front();
    tests_run++;
    if (hd_a !== e.hex) begin
      tests_failed++; $display("[TB] FAIL post_reset_200 got %h want %h", hd_a, e.hex);
    end
  endtask

  task automatic test_on();
    exp_t e;
    bit   saw_busy;
    e = model(200, 3, 1'b1);
    @(negedge CLK);
    on_a = 1'b0;
    #1;
    tests_run++;
    if (hd_a !== 21'h1fffff || hp_a !== 14'h3fff) begin
      tests_failed++; $display("[TB] FAIL on_off got %h/%h want 1fffff/3fff", hd_a, hp_a);
    end
    saw_busy = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (busy_a) saw_busy = 1'b1;
    end
    on_a = 1'b1;
    #1;
    tests_run++;
    if (saw_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL on_reconvert got %b want 0", saw_busy);
    end
    tests_run++;
    if (hd_a !== e.hex || hp_a !== LV) begin
      tests_failed++; $display("[TB] FAIL on_restore got %h/%h want %h/%h", hd_a, hp_a, e.hex, LV);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow_no_blank();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    test_on();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d tests", tests_run);
    $fatal(1);
  end

endmodule
